// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline.
// Ports: ID/IDEX/EX/MEM hazard terms in; stage enables, flush, bubble, stats out.
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rt,
  input  logic             EX_BranchTaken,
  input  logic             EX_Jump,
  input  logic             MEM_Req,
  input  logic             MEM_Ready,
  output logic             PC_WriteEn,
  output logic             PC_SelTarget,
  output logic             IFID_WriteEn,
  output logic             IFID_Flush,
  output logic             IDEX_WriteEn,
  output logic             IDEX_Bubble,
  output logic             EXMEM_WriteEn,
  output logic             MEMWB_WriteEn,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic             MemTimeout
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERR
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  logic memwait;
  logic lu;
  logic redirect;
  logic halt;
  logic stall_ev;
  logic flush_ev;

  assign memwait  = MEM_Req & ~MEM_Ready;
  assign redirect = EX_BranchTaken | EX_Jump;
  assign halt     = rst | (state == ERR);

  // A load into $0 never produces a value, so it cannot cause a hazard.
  assign lu = IDEX_MemRead & (IDEX_Rt != 5'd0) &
              ((ID_UsesRs & (ID_Rs == IDEX_Rt)) |
               (ID_UsesRt & (ID_Rt == IDEX_Rt)));

  always_comb begin
    PC_WriteEn    = 1'b0;
    PC_SelTarget  = 1'b0;
    IFID_WriteEn  = 1'b0;
    IFID_Flush    = 1'b0;
    IDEX_WriteEn  = 1'b0;
    IDEX_Bubble   = 1'b0;
    EXMEM_WriteEn = 1'b0;
    MEMWB_WriteEn = 1'b0;
    stall_ev      = 1'b0;
    flush_ev      = 1'b0;
    priority case (1'b1)
      halt: begin
      end
      // Full freeze; redirect/lu are re-evaluated once memory answers.
      memwait: begin
        stall_ev = 1'b1;
      end
      // The ID instruction is squashed, so any load-use on it is moot.
      redirect: begin
        PC_WriteEn    = 1'b1;
        PC_SelTarget  = 1'b1;
        IFID_WriteEn  = 1'b1;
        IFID_Flush    = 1'b1;
        IDEX_WriteEn  = 1'b1;
        IDEX_Bubble   = 1'b1;
        EXMEM_WriteEn = 1'b1;
        MEMWB_WriteEn = 1'b1;
        flush_ev      = 1'b1;
      end
      lu: begin
        IDEX_WriteEn  = 1'b1;
        IDEX_Bubble   = 1'b1;
        EXMEM_WriteEn = 1'b1;
        MEMWB_WriteEn = 1'b1;
        stall_ev      = 1'b1;
      end
      default: begin
        PC_WriteEn    = 1'b1;
        IFID_WriteEn  = 1'b1;
        IDEX_WriteEn  = 1'b1;
        EXMEM_WriteEn = 1'b1;
        MEMWB_WriteEn = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      wait_cnt   <= '0;
      StallCnt   <= '0;
      FlushCnt   <= '0;
      MemTimeout <= 1'b0;
    end else begin
      if (stall_ev && (StallCnt != '1))
        StallCnt <= StallCnt + CNT_W'(1);
      if (flush_ev && (FlushCnt != '1))
        FlushCnt <= FlushCnt + CNT_W'(1);
      unique case (state)
        RUN: begin
          if (memwait) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          // A dropped request counts as completion.
          if (!memwait) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            state      <= ERR;
            MemTimeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ERR: begin
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl.
// Two instances: A (timeout 4, 16-bit counters), B (2-bit counters).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, idex_rt;
  logic       uses_rs, uses_rt, idex_mr;
  logic       br, jmp, mreq, mrdy;

  logic        a_pc, a_sel, a_ifid, a_fl, a_idex, a_bub, a_exm, a_mwb;
  logic [15:0] a_stall, a_flush;
  logic        a_to;
  logic        b_pc, b_sel, b_ifid, b_fl, b_idex, b_bub, b_exm, b_mwb;
  logic [1:0]  b_stall, b_flush;
  logic        b_to;

  logic [7:0] ctl_a, ctl_b;
  assign ctl_a = {a_pc, a_sel, a_ifid, a_fl, a_idex, a_bub, a_exm, a_mwb};
  assign ctl_b = {b_pc, b_sel, b_ifid, b_fl, b_idex, b_bub, b_exm, b_mwb};

  localparam logic [7:0] NRM = 8'b1010_1011;
  localparam logic [7:0] RED = 8'b1111_1111;
  localparam logic [7:0] LDU = 8'b0000_1111;
  localparam logic [7:0] OFF = 8'b0000_0000;

  typedef struct {
    string       tag;
    logic [7:0]  ca;
    logic [7:0]  cb;
    logic [15:0] sa;
    logic [15:0] fa;
    logic        ta;
    logic [1:0]  sb;
  } exp_t;

  exp_t sbq[$];
  int   vecs = 0;
  int   miss = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst),
    .ID_Rs(id_rs), .ID_Rt(id_rt),
    .ID_UsesRs(uses_rs), .ID_UsesRt(uses_rt),
    .IDEX_MemRead(idex_mr), .IDEX_Rt(idex_rt),
    .EX_BranchTaken(br), .EX_Jump(jmp),
    .MEM_Req(mreq), .MEM_Ready(mrdy),
    .PC_WriteEn(a_pc), .PC_SelTarget(a_sel),
    .IFID_WriteEn(a_ifid), .IFID_Flush(a_fl),
    .IDEX_WriteEn(a_idex), .IDEX_Bubble(a_bub),
    .EXMEM_WriteEn(a_exm), .MEMWB_WriteEn(a_mwb),
    .StallCnt(a_stall), .FlushCnt(a_flush),
    .MemTimeout(a_to)
  );

  hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(255)) dut_b (
    .clk(clk), .rst(rst),
    .ID_Rs(id_rs), .ID_Rt(id_rt),
    .ID_UsesRs(uses_rs), .ID_UsesRt(uses_rt),
    .IDEX_MemRead(idex_mr), .IDEX_Rt(idex_rt),
    .EX_BranchTaken(br), .EX_Jump(jmp),
    .MEM_Req(mreq), .MEM_Ready(mrdy),
    .PC_WriteEn(b_pc), .PC_SelTarget(b_sel),
    .IFID_WriteEn(b_ifid), .IFID_Flush(b_fl),
    .IDEX_WriteEn(b_idex), .IDEX_Bubble(b_bub),
    .EXMEM_WriteEn(b_exm), .MEMWB_WriteEn(b_mwb),
    .StallCnt(b_stall), .FlushCnt(b_flush),
    .MemTimeout(b_to)
  );

  task automatic idle();
    id_rs   = 5'd0;
    id_rt   = 5'd0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    idex_mr = 1'b0;
    idex_rt = 5'd0;
    br      = 1'b0;
    jmp     = 1'b0;
    mreq    = 1'b0;
    mrdy    = 1'b0;
  endtask

  task automatic ldu(input logic [4:0] r);
    idex_mr = 1'b1;
    idex_rt = r;
    id_rs   = r;
    uses_rs = 1'b1;
  endtask

  // Push expectation with the stimulus, check at negedge, advance.
  task automatic step(input string tag,
                      input logic [7:0] ca, input logic [7:0] cb,
                      input logic [15:0] sa, input logic [15:0] fa,
                      input logic ta, input logic [1:0] sb);
    exp_t e;
    e.tag = tag; e.ca = ca; e.cb = cb;
    e.sa = sa; e.fa = fa; e.ta = ta; e.sb = sb;
    sbq.push_back(e);
    @(negedge clk);
    e = sbq.pop_front();
    vecs++;
    assert (ctl_a === e.ca) else begin
      miss++;
      $error("FAIL %s ctl_a got %b want %b", e.tag, ctl_a, e.ca);
    end
    vecs++;
    assert (ctl_b === e.cb) else begin
      miss++;
      $error("FAIL %s ctl_b got %b want %b", e.tag, ctl_b, e.cb);
    end
    vecs++;
    assert (a_stall === e.sa) else begin
      miss++;
      $error("FAIL %s stall_a got %0d want %0d", e.tag, a_stall, e.sa);
    end
    vecs++;
    assert (a_flush === e.fa) else begin
      miss++;
      $error("FAIL %s flush_a got %0d want %0d", e.tag, a_flush, e.fa);
    end
    vecs++;
    assert (a_to === e.ta) else begin
      miss++;
      $error("FAIL %s timeout_a got %b want %b", e.tag, a_to, e.ta);
    end
    vecs++;
    assert (b_stall === e.sb) else begin
      miss++;
      $error("FAIL %s stall_b got %0d want %0d", e.tag, b_stall, e.sb);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("reset", OFF, OFF, 0, 0, 0, 0);
    rst = 1'b0;
    step("run", NRM, NRM, 0, 0, 0, 0);
    ldu(5'd5);
    step("lu_rs", LDU, LDU, 0, 0, 0, 0);
    idle();
    step("after_lu", NRM, NRM, 1, 0, 0, 1);
    ldu(5'd0);
    id_rt = 5'd0;
    uses_rt = 1'b1;
    step("lw_r0", NRM, NRM, 1, 0, 0, 1);
    idle();
    step("after_r0", NRM, NRM, 1, 0, 0, 1);
    idex_mr = 1'b1; idex_rt = 5'd7;
    id_rt = 5'd7; uses_rt = 1'b1;
    id_rs = 5'd7; uses_rs = 1'b0;
    step("lu_rt", LDU, LDU, 1, 0, 0, 1);
    idle();
    idex_mr = 1'b1; idex_rt = 5'd9;
    id_rs = 5'd9; uses_rs = 1'b0;
    id_rt = 5'd3; uses_rt = 1'b1;
    step("no_use", NRM, NRM, 2, 0, 0, 2);
    idle();
    ldu(5'd5);
    br = 1'b1;
    step("br_lu", RED, RED, 2, 0, 0, 2);
    idle();
    jmp = 1'b1;
    step("jump", RED, RED, 2, 1, 0, 2);
    idle();
    step("after_jmp", NRM, NRM, 2, 2, 0, 2);
    mreq = 1'b1; br = 1'b1;
    step("frz1", OFF, OFF, 2, 2, 0, 2);
    br = 1'b0;
    step("frz2", OFF, OFF, 3, 2, 0, 3);
    step("frz3", OFF, OFF, 4, 2, 0, 3);
    mrdy = 1'b1;
    step("ready", NRM, NRM, 5, 2, 0, 3);
    idle();
    step("post_rdy", NRM, NRM, 5, 2, 0, 3);
    mreq = 1'b1;
    step("frz_drop", OFF, OFF, 5, 2, 0, 3);
    mreq = 1'b0;
    step("req_drop", NRM, NRM, 6, 2, 0, 3);
    step("post_drop", NRM, NRM, 6, 2, 0, 3);
    mreq = 1'b1;
    for (int i = 0; i < 5; i++)
      step("tmo_wait", OFF, OFF, 16'(6 + i), 2, 0, 3);
    step("err", OFF, OFF, 11, 2, 1, 3);
    mrdy = 1'b1; br = 1'b1;
    step("err_hold", OFF, RED, 11, 2, 1, 3);
    idle();
    rst = 1'b1;
    step("rst_err", OFF, OFF, 11, 2, 1, 3);
    rst = 1'b0;
    step("rst_clr", NRM, NRM, 0, 0, 0, 0);
    ldu(5'd12);
    for (int i = 0; i < 5; i++)
      step("sat_lu", LDU, LDU, 16'(i), 0, 0,
           (i > 3) ? 2'd3 : 2'(i));
    idle();
    step("sat_end", NRM, NRM, 5, 0, 0, 3);
    if (sbq.size() != 0) begin
      miss++;
      $display("FAIL scoreboard left %0d want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
